microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
- Micro-program sequencer. It sits between the 14 control-word ROMs (112-bit control word) and the datapath.
- Each cycle it does three things:
  - holds the current micro-address,
  - registers the ROM output into the control-word pipeline register that drives the datapath,
  - computes the next micro-address from the word's typ, offset, cond and escape fields plus CPU/micro flags, IR opcode and interrupt/DMA requests.

Parameters:
- U_ADDR_W, 14, micro-address width (8-bit opcode x 64 steps).
- CW_W, 112, control word width (14 ROMs x 8).
- RESET_ADDR, 14'h0000, micro-address after reset.
- FETCH_ADDR, 14'h0010, start of the fetch micro-routine (target of escape).
- INT_ADDR, 14'h3F80, interrupt entry micro-routine.
- DMA_ADDR, 14'h3FC0, DMA grant micro-routine.
- CW_NOP, all zeros, value loaded into cw_q on reset/halt bubble.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- cw_in  in  CW_W  control word read combinationally from ROMs at u_addr.
- u_addr  out  U_ADDR_W  registered micro-address to ROM address pins.
- cw_q  out  CW_W  registered control word to datapath.
- stall  in  1  memory wait; freezes u_addr and cw_q.
- zf, cf, sf, of  in  1 each  CPU status flags.
- u_zf, u_cf, u_sf, u_of  in  1 each  microcode flags.
- ir_opcode  in  8  instruction register contents.
- irq_pending  in  1  unmasked interrupt pending.
- irq_en  in  1  status irq enable bit.
- dma_req  in  1  DMA request.
- halt  in  1  status halt bit.
- cond_true  out  1  evaluated condition (debug/display).

Behaviour:
- Field extraction from cw_in:
  - typ = bits[1:0].
  - offset = bits[8:2], 7-bit two's complement.
  - cond_invert = bit 9.
  - cond_flag_src = bit 10 (0 = CPU flags, 1 = micro flags).
  - cond_sel = bits[14:11].
  - escape = bit 15.
- Flag set F = {Z,C,S,O}, chosen from either CPU or micro flags by cond_flag_src.
- cond_sel selects the raw condition:
  - 0 Z; 1 C; 2 S; 3 O;
  - 4 Z|C; 5 S^O; 6 (S^O)|Z;
  - 7 dma_req; 8 irq_pending & irq_en;
  - 9 constant 1;
  - 10-15 constant 0.
- cond_true = raw condition XOR cond_invert. It is combinational.
- Relative target T = u_addr + 1 + sext(offset). Arithmetic is modulo 2^U_ADDR_W; wrap is silent (3FFF + 1 → 0000).
- Next address, priority high to low:
  1. escape=1 → FETCH_ADDR. Overrides typ.
  2. typ=00 (jump) → T. Offset 0 gives sequential execution.
  3. typ=01 (branch) → T if cond_true, else u_addr + 1.
  4. typ=10 (fetch check):
     - halt=1 → u_addr (spin);
     - else irq_pending & irq_en → INT_ADDR;
     - else dma_req → DMA_ADDR;
     - else u_addr + 1.
     - Interrupt beats DMA when both are present.
  5. typ=11 (dispatch) → {ir_opcode, 6'b0}.
- Registers update on the rising clk edge when stall=0:
  - u_addr ← next;
  - cw_q ← cw_in, except in the halt spin of case 4, where cw_q ← CW_NOP.
- stall=1: u_addr and cw_q hold. Flags and requests sampled during stall are ignored until stall deasserts.
- Latency:
  - The ROM word at address A appears on cw_q exactly 1 cycle after u_addr = A.
  - A branch decision uses the flags present in the same cycle, i.e. flags produced by the previous cw_q step.
- Reset (arst_n low, asynchronous, any time including mid-routine):
  - u_addr = RESET_ADDR, cw_q = CW_NOP, immediately.
  - On release, the first edge loads ROM[RESET_ADDR] into cw_q.
- No internal state beyond u_addr and cw_q. Fields outside bits[15:0] pass through to cw_q untouched.

Test Plan:
- Reset: assert arst_n low mid-run with u_addr=0x0123 → u_addr=0x0000 and cw_q=0 without a clock. Release → cw_q=ROM[0] after 1 edge.
- Jump/wrap:
  - u_addr=0x3FFF, typ=00, offset=0 → u_addr=0x0000.
  - u_addr=0x0040, offset=7'h7E (−2) → 0x003F.
- Branch:
  - u_addr=0x0100, typ=01, cond_sel=5, S=1, O=0, invert=0, offset=4 → 0x0105.
  - Same word with invert=1 → 0x0101.
  - flag_src=1 selects u_* flags.
- Fetch check:
  - typ=10, irq_pending=1, irq_en=1, dma_req=1 → INT_ADDR 0x3F80.
  - irq_en=0 → DMA_ADDR 0x3FC0.
  - halt=1 → u_addr holds, cw_q=0.
- Dispatch/escape:
  - typ=11, ir_opcode=0xA5 → u_addr=0x2940.
  - escape=1 with typ=11 → FETCH_ADDR 0x0010.
- Stall: stall=1 for 3 cycles during typ=01 with a toggling flag → u_addr and cw_q frozen. After release, the branch uses the current flag value.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Micro-program sequencer: holds the micro-address, pipelines the ROM control
// word to the datapath and computes the next micro-address from the word's fields.
module microcode_sequencer #(
    parameter int unsigned          U_ADDR_W   = 14,
    parameter int unsigned          CW_W       = 112,
    parameter logic [U_ADDR_W-1:0]  RESET_ADDR = 14'h0000,
    parameter logic [U_ADDR_W-1:0]  FETCH_ADDR = 14'h0010,
    parameter logic [U_ADDR_W-1:0]  INT_ADDR   = 14'h3F80,
    parameter logic [U_ADDR_W-1:0]  DMA_ADDR   = 14'h3FC0,
    parameter logic [CW_W-1:0]      CW_NOP     = '0
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [CW_W-1:0]     cw_in,
    output logic [U_ADDR_W-1:0] u_addr,
    output logic [CW_W-1:0]     cw_q,
    input  logic                stall,
    input  logic                zf,
    input  logic                cf,
    input  logic                sf,
    input  logic                of,
    input  logic                u_zf,
    input  logic                u_cf,
    input  logic                u_sf,
    input  logic                u_of,
    input  logic [7:0]          ir_opcode,
    input  logic                irq_pending,
    input  logic                irq_en,
    input  logic                dma_req,
    input  logic                halt,
    output logic                cond_true
);

    localparam int unsigned OFF_W  = 7;
    localparam int unsigned STEP_W = 6;

    typedef enum logic [1:0] {
        TYP_JUMP     = 2'b00,
        TYP_BRANCH   = 2'b01,
        TYP_FETCH    = 2'b10,
        TYP_DISPATCH = 2'b11
    } typ_e;

    typ_e                typ;
    logic [OFF_W-1:0]    offset;
    logic                cond_invert;
    logic                cond_flag_src;
    logic [3:0]          cond_sel;
    logic                escape;
    logic [3:0]          flags;
    logic                raw_cond;
    logic [U_ADDR_W-1:0] seq_addr;
    logic [U_ADDR_W-1:0] rel_addr;
    logic [U_ADDR_W-1:0] next_addr;
    logic                halt_spin;

    // Field decode, condition select and next-address priority
    always_comb begin
        typ           = typ_e'(cw_in[1:0]);
        offset        = cw_in[8:2];
        cond_invert   = cw_in[9];
        cond_flag_src = cw_in[10];
        cond_sel      = cw_in[14:11];
        escape        = cw_in[15];

        flags = cond_flag_src ? {u_zf, u_cf, u_sf, u_of} : {zf, cf, sf, of};

        // flags = {Z, C, S, O}
        case (cond_sel)
            4'd0:    raw_cond = flags[3];
            4'd1:    raw_cond = flags[2];
            4'd2:    raw_cond = flags[1];
            4'd3:    raw_cond = flags[0];
            4'd4:    raw_cond = flags[3] | flags[2];
            4'd5:    raw_cond = flags[1] ^ flags[0];
            4'd6:    raw_cond = (flags[1] ^ flags[0]) | flags[3];
            4'd7:    raw_cond = dma_req;
            4'd8:    raw_cond = irq_pending & irq_en;
            4'd9:    raw_cond = 1'b1;
            default: raw_cond = 1'b0;
        endcase
        cond_true = raw_cond ^ cond_invert;

        seq_addr = u_addr + U_ADDR_W'(1);
        rel_addr = seq_addr + {{(U_ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};

        next_addr = seq_addr;
        halt_spin = 1'b0;
        if (escape) begin
            next_addr = FETCH_ADDR;
        end else begin
            case (typ)
                TYP_JUMP:     next_addr = rel_addr;
                TYP_BRANCH:   next_addr = cond_true ? rel_addr : seq_addr;
                TYP_FETCH: begin
                    if (halt) begin
                        next_addr = u_addr;
                        halt_spin = 1'b1;
                    end else if (irq_pending && irq_en) begin
                        next_addr = INT_ADDR;
                    end else if (dma_req) begin
                        next_addr = DMA_ADDR;
                    end else begin
                        next_addr = seq_addr;
                    end
                end
                TYP_DISPATCH: next_addr = U_ADDR_W'({ir_opcode, STEP_W'(0)});
                default:      next_addr = seq_addr;
            endcase
        end
    end

    // Micro-address and control-word pipeline, frozen while stalled
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            u_addr <= RESET_ADDR;
            cw_q   <= CW_NOP;
        end else if (!stall) begin
            u_addr <= next_addr;
            cw_q   <= halt_spin ? CW_NOP : cw_in;
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: vector table of control words with
// hand-computed next addresses, plus reset and stall sequences.
module tb_microcode_sequencer;

    logic         clk = 1'b0;
    logic         arst_n;
    logic [111:0] cw_in;
    logic [13:0]  u_addr;
    logic [111:0] cw_q;
    logic         stall;
    logic         zf, cf, sf, of;
    logic         u_zf, u_cf, u_sf, u_of;
    logic [7:0]   ir_opcode;
    logic         irq_pending, irq_en, dma_req, halt;
    logic         cond_true;

    int n_pass  = 0;
    int n_total = 0;

    microcode_sequencer dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .cw_in       (cw_in),
        .u_addr      (u_addr),
        .cw_q        (cw_q),
        .stall       (stall),
        .zf          (zf),
        .cf          (cf),
        .sf          (sf),
        .of          (of),
        .u_zf        (u_zf),
        .u_cf        (u_cf),
        .u_sf        (u_sf),
        .u_of        (u_of),
        .ir_opcode   (ir_opcode),
        .irq_pending (irq_pending),
        .irq_en      (irq_en),
        .dma_req     (dma_req),
        .halt        (halt),
        .cond_true   (cond_true)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [111:0] cw;
        logic [3:0]   f;      // {Z,C,S,O} CPU flags
        logic [3:0]   uf;     // {Z,C,S,O} micro flags
        logic [7:0]   op;
        logic         irq;
        logic         ien;
        logic         dma;
        logic         hlt;
        logic         ecnd;
        logic [13:0]  eaddr;
        logic         enop;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vec [NVEC];

    function automatic logic [111:0] mk(input logic [1:0] typ, input logic [6:0] off,
                                        input logic inv, input logic src,
                                        input logic [3:0] sel, input logic esc,
                                        input logic [15:0] tag);
        logic [111:0] w;
        w = '0;
        w[111:96] = 16'hC0DE;
        w[63:48]  = ~tag;
        w[31:16]  = tag;
        w[1:0]    = typ;
        w[8:2]    = off;
        w[9]      = inv;
        w[10]     = src;
        w[14:11]  = sel;
        w[15]     = esc;
        return w;
    endfunction

    function automatic vec_t rw(input logic [111:0] cw, input logic [3:0] f, input logic [3:0] uf,
                                input logic [7:0] op, input logic irq, input logic ien,
                                input logic dma, input logic hlt, input logic ecnd,
                                input logic [13:0] eaddr, input logic enop);
        vec_t v;
        v.cw = cw; v.f = f; v.uf = uf; v.op = op; v.irq = irq; v.ien = ien;
        v.dma = dma; v.hlt = hlt; v.ecnd = ecnd; v.eaddr = eaddr; v.enop = enop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_inputs();
        {zf, cf, sf, of} = 4'b0;
        {u_zf, u_cf, u_sf, u_of} = 4'b0;
        ir_opcode = 8'h00;
        irq_pending = 1'b0; irq_en = 1'b0; dma_req = 1'b0; halt = 1'b0;
        stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [111:0] w0, w1, w_hold, w_br;

    initial begin
        // Rows chain: each starts at the previous row's expected u_addr (first at 0x0000)
        vec[0]  = rw(mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'd0),  4'h0, 4'h0, 8'hA5, 0, 0, 0, 0, 0, 14'h2940, 0);
        vec[1]  = rw(mk(2'd0, 7'h00, 0, 0, 4'd10, 0, 16'd1),  4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 14'h2941, 0);
        vec[2]  = rw(mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'd2),  4'h0, 4'h0, 8'hFF, 0, 0, 0, 0, 0, 14'h3FC0, 0);
        vec[3]  = rw(mk(2'd0, 7'h3E, 0, 0, 4'd10, 0, 16'd3),  4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 14'h3FFF, 0);
        vec[4]  = rw(mk(2'd0, 7'h00, 0, 0, 4'd10, 0, 16'd4),  4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0);
        vec[5]  = rw(mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'd5),  4'h0, 4'h0, 8'h01, 0, 0, 0, 0, 0, 14'h0040, 0);
        vec[6]  = rw(mk(2'd0, 7'h7E, 0, 0, 4'd10, 0, 16'd6),  4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 14'h003F, 0);
        vec[7]  = rw(mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'd7),  4'h0, 4'h0, 8'h04, 0, 0, 0, 0, 0, 14'h0100, 0);
        vec[8]  = rw(mk(2'd1, 7'h04, 0, 0, 4'd5,  0, 16'd8),  4'h2, 4'h0, 8'h00, 0, 0, 0, 0, 1, 14'h0105, 0);
        vec[9]  = rw(mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'd9),  4'h0, 4'h0, 8'h04, 0, 0, 0, 0, 0, 14'h0100, 0);
        vec[10] = rw(mk(2'd1, 7'h04, 1, 0, 4'd5,  0, 16'd10), 4'h2, 4'h0, 8'h00, 0, 0, 0, 0, 0, 14'h0101, 0);
        vec[11] = rw(mk(2'd1, 7'h02, 0, 1, 4'd0,  0, 16'd11), 4'h0, 4'h8, 8'h00, 0, 0, 0, 0, 1, 14'h0104, 0);
        vec[12] = rw(mk(2'd1, 7'h02, 0, 0, 4'd0,  0, 16'd12), 4'h0, 4'h8, 8'h00, 0, 0, 0, 0, 0, 14'h0105, 0);
        vec[13] = rw(mk(2'd2, 7'h00, 0, 0, 4'd8,  0, 16'd13), 4'h0, 4'h0, 8'h00, 1, 1, 1, 0, 1, 14'h3F80, 0);
        vec[14] = rw(mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'd14), 4'h0, 4'h0, 8'h04, 0, 0, 0, 0, 0, 14'h0100, 0);
        vec[15] = rw(mk(2'd2, 7'h00, 0, 0, 4'd7,  0, 16'd15), 4'h0, 4'h0, 8'h00, 1, 0, 1, 0, 1, 14'h3FC0, 0);
        vec[16] = rw(mk(2'd2, 7'h00, 1, 0, 4'd9,  0, 16'd16), 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 14'h3FC1, 0);
        vec[17] = rw(mk(2'd3, 7'h00, 0, 0, 4'd10, 1, 16'd17), 4'h0, 4'h0, 8'hA5, 0, 0, 0, 0, 0, 14'h0010, 0);
        vec[18] = rw(mk(2'd2, 7'h00, 0, 0, 4'd10, 0, 16'd18), 4'h0, 4'h0, 8'h00, 1, 1, 0, 1, 0, 14'h0010, 1);
        vec[19] = rw(mk(2'd2, 7'h00, 0, 0, 4'd10, 1, 16'd19), 4'h0, 4'h0, 8'h00, 0, 0, 0, 1, 0, 14'h0010, 0);
        vec[20] = rw(mk(2'd1, 7'h00, 0, 0, 4'd4,  0, 16'd20), 4'h4, 4'h0, 8'h00, 0, 0, 0, 0, 1, 14'h0011, 0);
        vec[21] = rw(mk(2'd1, 7'h05, 0, 0, 4'd6,  0, 16'd21), 4'h3, 4'h0, 8'h00, 0, 0, 0, 0, 0, 14'h0012, 0);
        vec[22] = rw(mk(2'd1, 7'h7F, 0, 0, 4'd3,  0, 16'd22), 4'h1, 4'h0, 8'h00, 0, 0, 0, 0, 1, 14'h0012, 0);
        vec[23] = rw(mk(2'd1, 7'h03, 0, 0, 4'd12, 0, 16'd23), 4'hF, 4'hF, 8'h00, 0, 0, 0, 0, 0, 14'h0013, 0);

        // Reset state and first word after release
        clear_inputs();
        arst_n = 1'b0;
        w0 = mk(2'd0, 7'h00, 0, 0, 4'd10, 0, 16'hAAAA);
        cw_in = w0;
        #2;
        chk("reset_u_addr", 112'(u_addr), 112'h0);
        chk("reset_cw_q", cw_q, '0);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        chk("release_cw_q", cw_q, w0);
        chk("release_u_addr", 112'(u_addr), 112'h1);

        // Walk to 0x0123 then reset asynchronously mid-cycle
        cw_in = mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'hB001);
        ir_opcode = 8'h04;
        tick();
        cw_in = mk(2'd0, 7'h22, 0, 0, 4'd10, 0, 16'hB002);
        tick();
        chk("pre_reset_u_addr", 112'(u_addr), 112'h0123);
        #2;
        arst_n = 1'b0;
        #1;
        chk("async_reset_u_addr", 112'(u_addr), 112'h0);
        chk("async_reset_cw_q", cw_q, '0);
        @(negedge clk);
        arst_n = 1'b1;
        w1 = mk(2'd3, 7'h00, 0, 0, 4'd10, 0, 16'hB003);
        cw_in = w1;
        ir_opcode = 8'h00;
        tick();
        chk("rerelease_cw_q", cw_q, w1);
        chk("rerelease_u_addr", 112'(u_addr), 112'h0);

        // Table vectors
        for (int i = 0; i < NVEC; i++) begin
            cw_in = vec[i].cw;
            {zf, cf, sf, of} = vec[i].f;
            {u_zf, u_cf, u_sf, u_of} = vec[i].uf;
            ir_opcode = vec[i].op;
            irq_pending = vec[i].irq;
            irq_en = vec[i].ien;
            dma_req = vec[i].dma;
            halt = vec[i].hlt;
            #1;
            chk($sformatf("vec%0d_cond", i), 112'(cond_true), 112'(vec[i].ecnd));
            tick();
            chk($sformatf("vec%0d_u_addr", i), 112'(u_addr), 112'(vec[i].eaddr));
            chk($sformatf("vec%0d_cw_q", i), cw_q, vec[i].enop ? 112'h0 : vec[i].cw);
        end

        // Stall during a branch on Z while Z toggles; u_addr is 0x0013 here
        clear_inputs();
        w_hold = vec[NVEC-1].cw;
        w_br = mk(2'd1, 7'h08, 0, 0, 4'd0, 0, 16'h5A5A);
        cw_in = w_br;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            zf = (c % 2 == 0);
            tick();
            chk($sformatf("stall%0d_u_addr", c), 112'(u_addr), 112'h0013);
            chk($sformatf("stall%0d_cw_q", c), cw_q, w_hold);
        end
        zf = 1'b0;
        #2;
        stall = 1'b0;
        zf = 1'b1;
        tick();
        chk("unstall_u_addr", 112'(u_addr), 112'h001C);
        chk("unstall_cw_q", cw_q, w_br);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
